// File: rtl/lcm_gcd_host.sv
// lcm_gcd_host: handshake front-end for an external GCD/LCM compute unit.
// It accepts an operand pair, rejects zero operands, starts the compute unit,
// waits for its result with a timeout, and cross-checks gcd*lcm == a*b before
// presenting the result downstream.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_vld/in_rdy        upstream handshake; in_a/in_b operands
//   cu_en                one-cycle start pulse to the compute unit
//   cu_a/cu_b            latched operands to the compute unit
//   cu_ready             compute unit idle
//   cu_vld               compute unit result pulse; cu_gcd/cu_lcm results
//   out_vld/out_rdy      downstream handshake
//   out_gcd/out_lcm      results; out_err 00 ok, 01 zero, 10 timeout, 11 mismatch
module lcm_gcd_host #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DATAWIDTH-1:0]   in_a,
  input  logic [DATAWIDTH-1:0]   in_b,
  output logic                   cu_en,
  output logic [DATAWIDTH-1:0]   cu_a,
  output logic [DATAWIDTH-1:0]   cu_b,
  input  logic                   cu_ready,
  input  logic                   cu_vld,
  input  logic [DATAWIDTH-1:0]   cu_gcd,
  input  logic [2*DATAWIDTH-1:0] cu_lcm,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DATAWIDTH-1:0]   out_gcd,
  output logic [2*DATAWIDTH-1:0] out_lcm,
  output logic [1:0]             out_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ZERO     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISMATCH = 2'b11;

  // Counter value of the last permitted WAIT cycle: WAIT lasts TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t                 state_r;
  logic [15:0]            cnt_r;
  logic [DATAWIDTH-1:0]   a_r;
  logic [DATAWIDTH-1:0]   b_r;
  logic [DATAWIDTH-1:0]   res_gcd_r;
  logic [2*DATAWIDTH-1:0] res_lcm_r;
  logic                   in_rdy_r;
  logic                   out_vld_r;
  logic [DATAWIDTH-1:0]   out_gcd_r;
  logic [2*DATAWIDTH-1:0] out_lcm_r;
  logic [1:0]             out_err_r;

  // True when gcd*lcm (3W wide, no overflow) differs from zero-extended a*b.
  function automatic logic result_mismatch(
    input logic [DATAWIDTH-1:0]   g,
    input logic [2*DATAWIDTH-1:0] l,
    input logic [DATAWIDTH-1:0]   a,
    input logic [DATAWIDTH-1:0]   b
  );
    logic [3*DATAWIDTH-1:0] gl;
    logic [3*DATAWIDTH-1:0] ab;
    gl = {{(2*DATAWIDTH){1'b0}}, g} * {{DATAWIDTH{1'b0}}, l};
    ab = {{(2*DATAWIDTH){1'b0}}, a} * {{(2*DATAWIDTH){1'b0}}, b};
    return (gl != ab);
  endfunction

  assign in_rdy  = in_rdy_r;
  assign out_vld = out_vld_r;
  assign out_gcd = out_gcd_r;
  assign out_lcm = out_lcm_r;
  assign out_err = out_err_r;
  assign cu_a    = a_r;
  assign cu_b    = b_r;
  // Start pulse follows cu_ready directly so ISSUE lasts exactly one cycle once idle.
  assign cu_en   = (state_r == S_ISSUE) && cu_ready;

  // Transaction FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      cnt_r     <= 16'd0;
      a_r       <= {DATAWIDTH{1'b0}};
      b_r       <= {DATAWIDTH{1'b0}};
      res_gcd_r <= {DATAWIDTH{1'b0}};
      res_lcm_r <= {(2*DATAWIDTH){1'b0}};
      in_rdy_r  <= 1'b1;
      out_vld_r <= 1'b0;
      out_gcd_r <= {DATAWIDTH{1'b0}};
      out_lcm_r <= {(2*DATAWIDTH){1'b0}};
      out_err_r <= ERR_OK;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_vld && in_rdy_r) begin
            a_r      <= in_a;
            b_r      <= in_b;
            in_rdy_r <= 1'b0;
            if ((in_a == {DATAWIDTH{1'b0}}) || (in_b == {DATAWIDTH{1'b0}})) begin
              out_gcd_r <= {DATAWIDTH{1'b0}};
              out_lcm_r <= {(2*DATAWIDTH){1'b0}};
              out_err_r <= ERR_ZERO;
              out_vld_r <= 1'b1;
              state_r   <= S_OUT;
            end else begin
              state_r <= S_ISSUE;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (cu_ready) begin
            cnt_r   <= 16'd0;
            state_r <= S_WAIT;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins over timeout.
          if (cu_vld) begin
            res_gcd_r <= cu_gcd;
            res_lcm_r <= cu_lcm;
            state_r   <= S_CHECK;
          end else if (cnt_r >= TMO_LAST) begin
            out_gcd_r <= {DATAWIDTH{1'b0}};
            out_lcm_r <= {(2*DATAWIDTH){1'b0}};
            out_err_r <= ERR_TIMEOUT;
            out_vld_r <= 1'b1;
            state_r   <= S_OUT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_CHECK: begin
          out_gcd_r <= res_gcd_r;
          out_lcm_r <= res_lcm_r;
          out_err_r <= result_mismatch(res_gcd_r, res_lcm_r, a_r, b_r) ?
                       ERR_MISMATCH : ERR_OK;
          out_vld_r <= 1'b1;
          state_r   <= S_OUT;
        end
        S_OUT: begin
          if (out_rdy) begin
            out_vld_r <= 1'b0;
            in_rdy_r  <= 1'b1;
            state_r   <= S_IDLE;
          end else begin
            state_r <= S_OUT;
          end
        end
        default: begin
          in_rdy_r  <= 1'b1;
          out_vld_r <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcm_gcd_host.md
LCM_GCD_HOST -- requirements
Module: lcm_gcd_host

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, operand width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum WAIT-state cycles before abort (range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_vld  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_rdy  output  1  host can accept an operand pair.
REQ-007 SHALL have ports in_a, in_b  input  DATAWIDTH  operands.
REQ-008 SHALL have port cu_en  output  1  start pulse to compute unit.
REQ-009 SHALL have ports cu_a, cu_b  output  DATAWIDTH  operands to compute unit.
REQ-010 SHALL have port cu_ready  input  1  compute unit idle.
REQ-011 SHALL have port cu_vld  input  1  compute unit one-cycle result pulse.
REQ-012 SHALL have ports cu_gcd  input  DATAWIDTH  and cu_lcm  input  2*DATAWIDTH  compute unit results.
REQ-013 SHALL have port out_vld  output  1  result valid to downstream.
REQ-014 SHALL have port out_rdy  input  1  downstream accepts result.
REQ-015 SHALL have ports out_gcd  output  DATAWIDTH  and out_lcm  output  2*DATAWIDTH  results.
REQ-016 SHALL have port out_err  output  2  status: 00 ok, 01 zero operand, 10 timeout, 11 check mismatch.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, CHECK, OUT; one state per cycle minimum.
REQ-018 IDLE: in_rdy=1; on in_vld&in_rdy latch in_a/in_b; if either is 0 go to OUT with out_err=01, gcd=0, lcm=0, no cu_en; else go to ISSUE.
REQ-019 in_rdy SHALL be 0 in every state other than IDLE.
REQ-020 cu_a/cu_b SHALL continuously drive the latched operands.
REQ-021 ISSUE: cu_en=cu_ready (combinational); on cu_en=1 go to WAIT, clear timeout counter; stay in ISSUE indefinitely while cu_ready=0.
REQ-022 cu_en SHALL be asserted in no state other than ISSUE, hence at most one cycle per operand pair.
REQ-023 WAIT: counter increments each cycle; on cu_vld=1 capture cu_gcd/cu_lcm and go to CHECK.
REQ-024 WAIT: if counter reaches TIMEOUT with cu_vld=0, go to OUT with out_err=10, gcd=0, lcm=0; cu_vld in that same cycle takes priority over timeout.
REQ-025 CHECK: compute gcd*lcm at 3*DATAWIDTH width vs zero-extended a*b (2*DATAWIDTH); mismatch -> out_err=11, else 00; results passed unchanged; go to OUT.
REQ-026 OUT: out_vld=1, out_gcd/out_lcm/out_err stable until out_rdy=1; on out_vld&out_rdy go to IDLE (next pair accepted no earlier than following cycle).
REQ-027 cu_vld outside WAIT (late pulse after timeout) SHALL be ignored with no state or output change.
REQ-028 Latency for a valid pair with cu_ready=1 and out_rdy=1: in handshake at cycle 0, cu_en at cycle 1, out_vld the cycle after CHECK, i.e. 2 cycles after cu_vld.
REQ-029 Zero-operand path latency: out_vld at cycle 1 after in handshake.
REQ-030 Unknown state encodings SHALL return to IDLE next cycle.

Reset
REQ-031 On rstn=0, asynchronously: state=IDLE, counter=0, latched operands=0, out_gcd=0, out_lcm=0, out_err=00, out_vld=0, cu_en=0; in_rdy=1 once in IDLE.
REQ-032 Reset mid-WAIT SHALL abandon the transaction; no output produced for it; subsequent cu_vld ignored.

Verification
REQ-033 in_a=12, in_b=18, model returns gcd=6, lcm=36 -> cu_en one cycle, out_gcd=6, out_lcm=36, out_err=00.
REQ-034 in_a=0, in_b=5 -> cu_en never asserted, out_vld at cycle 1, out_gcd=0, out_lcm=0, out_err=01.
REQ-035 TIMEOUT=16, model never pulses cu_vld -> out_vld after 16 WAIT cycles, out_err=10; late cu_vld ignored.
REQ-036 in_a=12, in_b=18, model returns gcd=4, lcm=36 -> out_gcd=4, out_lcm=36, out_err=11.
REQ-037 in_a=255, in_b=254, cu_ready held low 3 cycles, out_rdy low 5 cycles -> cu_en only after cu_ready rises; out_gcd=1, out_lcm=64770 held stable, in_rdy=0 throughout.
REQ-038 rstn pulsed low during WAIT -> all outputs at reset values immediately, in_rdy=1, new pair 6,4 gives out_gcd=2, out_lcm=12, out_err=00.
